result_dump_controller: RTL and testbench

- Downstream of the CPU. When PROCESS_DONE rises, it walks the result-matrix region of data RAM through a spare read port.
- Each 16-bit element is serialized as two bytes on a valid/ready byte stream, for a UART transmitter or bench monitor.
- It gives post-run visibility of the matrix-multiplication result without halting or modifying the CPU.

---
 rtl/kryp_dump_pkg.sv | 26 ++
 rtl/rising_edge_detect.sv | 25 ++
 rtl/result_dump_controller.sv | 117 +++++++++++
 tb/tb_result_dump_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kryp_dump_pkg.sv
// rtl/kryp_dump_pkg.sv - shared constants and state encoding for the result dump controller
// Purpose: state encoding, stream byte width and RAM read latency shared by the
//          result dump controller and its helpers.
// Ports:   none (package).
package kryp_dump_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_SEND_HI = 3'd3;
  localparam logic [2:0] ST_SEND_LO = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;

  localparam int BYTE_WIDTH     = 8;
  localparam int RAM_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_READ    = ST_READ,
    S_WAIT    = ST_WAIT,
    S_SEND_HI = ST_SEND_HI,
    S_SEND_LO = ST_SEND_LO,
    S_FINISH  = ST_FINISH
  } dump_state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// rtl/rising_edge_detect.sv - single-cycle pulse on a 0->1 transition of a level flag
// Purpose: flags the cycle in which IN is 1 and was 0 on the previous clock.
//          The history register resets to 0, so a flag already high when reset
//          releases produces a pulse on the first cycle after reset.
// Ports:   MAIN_CLOCK - clock
//          RESET      - synchronous active-high reset
//          IN         - level input being watched
//          PULSE      - high while IN=1 and the previous sample was 0
module rising_edge_detect (
  input  logic MAIN_CLOCK,
  input  logic RESET,
  input  logic IN,
  output logic PULSE
);

  logic prev;

  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) prev <= 1'b0;
    else       prev <= IN;
  end

  assign PULSE = IN & ~prev;

endmodule

// File: rtl/result_dump_controller.sv
// rtl/result_dump_controller.sv - streams the result matrix out of data RAM as bytes after the CPU finishes
// Purpose: on a rising PROCESS_DONE, reads ROWS*COLS words from RESULT_BASE
//          upwards (row-major, address wraps) through a spare RAM read port and
//          emits each word high byte first on a valid/ready byte stream.
// Ports:   MAIN_CLOCK, RESET          - clock, synchronous active-high reset
//          PROCESS_DONE               - CPU finished flag (level)
//          RAM_ADDR, RAM_RD_EN        - read request, data returned next cycle
//          RAM_DATA                   - read data
//          OUT_BYTE, OUT_VALID        - stream byte and its valid
//          OUT_READY                  - consumer accepts OUT_BYTE
//          DUMP_BUSY, DUMP_DONE       - dump in progress / finished (held until re-arm)
module result_dump_controller
  import kryp_dump_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESULT_BASE = 16'd0,
  parameter int                    ROWS        = 3,
  parameter int                    COLS        = 3
) (
  input  logic                  MAIN_CLOCK,
  input  logic                  RESET,
  input  logic                  PROCESS_DONE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic                  RAM_RD_EN,
  input  logic [DATA_WIDTH-1:0] RAM_DATA,
  output logic [BYTE_WIDTH-1:0] OUT_BYTE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  DUMP_BUSY,
  output logic                  DUMP_DONE
);

  localparam int NUM_ELEMS = ROWS * COLS;
  localparam int CNT_W     = $clog2(NUM_ELEMS + 1);
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(NUM_ELEMS - 1);

  dump_state_t           state;
  logic [CNT_W-1:0]      elem_cnt;
  logic [BYTE_WIDTH-1:0] lo_byte;
  logic                  trigger;

  rising_edge_detect u_done_edge (
    .MAIN_CLOCK (MAIN_CLOCK),
    .RESET      (RESET),
    .IN         (PROCESS_DONE),
    .PULSE      (trigger)
  );

  // RAM_ADDR doubles as the element address counter. The high byte goes
  // straight to OUT_BYTE when the word arrives, so only the low byte is kept.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      state     <= S_IDLE;
      RAM_ADDR  <= RESULT_BASE;
      RAM_RD_EN <= 1'b0;
      OUT_BYTE  <= '0;
      OUT_VALID <= 1'b0;
      DUMP_BUSY <= 1'b0;
      DUMP_DONE <= 1'b0;
      elem_cnt  <= '0;
      lo_byte   <= '0;
    end else begin
      RAM_RD_EN <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            elem_cnt  <= '0;
            RAM_ADDR  <= RESULT_BASE;
            DUMP_BUSY <= 1'b1;
            RAM_RD_EN <= 1'b1;
            state     <= S_READ;
          end
        end
        S_READ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          lo_byte   <= RAM_DATA[BYTE_WIDTH-1:0];
          OUT_BYTE  <= RAM_DATA[DATA_WIDTH-1 -: BYTE_WIDTH];
          OUT_VALID <= 1'b1;
          state     <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (OUT_READY) begin
            OUT_BYTE <= lo_byte;
            state    <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            if (elem_cnt == LAST_ELEM) begin
              DUMP_BUSY <= 1'b0;
              DUMP_DONE <= 1'b1;
              state     <= S_FINISH;
            end else begin
              elem_cnt  <= elem_cnt + 1'b1;
              RAM_ADDR  <= RAM_ADDR + 1'b1;
              RAM_RD_EN <= 1'b1;
              state     <= S_READ;
            end
          end
        end
        S_FINISH: begin
          // Re-arm only once the CPU flag drops, so a held flag never repeats the dump.
          if (!PROCESS_DONE) begin
            DUMP_DONE <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_dump_controller.sv
// tb/tb_result_dump_controller.sv - self-checking bench for result_dump_controller
module tb_result_dump_controller;

  logic        clk;
  logic        rst;
  logic        pd     [2];
  logic        ready  [2];
  logic [15:0] addr   [2];
  logic        rd_en  [2];
  logic [15:0] rdata  [2];
  logic [7:0]  obyte  [2];
  logic        ovalid [2];
  logic        busy   [2];
  logic        done   [2];

  logic [15:0] mem    [2][65536];
  logic [7:0]  got    [2][$];
  logic [15:0] rd_log [2][$];

  logic        stall_prev [2];
  logic [7:0]  held       [2];

  int checks;
  int errors;

  // Instance A: 2x2 at 0x0010. Instance B: 3x3 at 0xFFFE (address wrap).
  result_dump_controller #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .RESULT_BASE(16'h0010), .ROWS(2), .COLS(2)
  ) u_dut_a (
    .MAIN_CLOCK(clk), .RESET(rst), .PROCESS_DONE(pd[0]),
    .RAM_ADDR(addr[0]), .RAM_RD_EN(rd_en[0]), .RAM_DATA(rdata[0]),
    .OUT_BYTE(obyte[0]), .OUT_VALID(ovalid[0]), .OUT_READY(ready[0]),
    .DUMP_BUSY(busy[0]), .DUMP_DONE(done[0])
  );

  result_dump_controller #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .RESULT_BASE(16'hFFFE), .ROWS(3), .COLS(3)
  ) u_dut_b (
    .MAIN_CLOCK(clk), .RESET(rst), .PROCESS_DONE(pd[1]),
    .RAM_ADDR(addr[1]), .RAM_RD_EN(rd_en[1]), .RAM_DATA(rdata[1]),
    .OUT_BYTE(obyte[1]), .OUT_VALID(ovalid[1]), .OUT_READY(ready[1]),
    .DUMP_BUSY(busy[1]), .DUMP_DONE(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Synchronous-read RAM per instance, logging every read address.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) begin
        rdata[i] <= mem[i][addr[i]];
        rd_log[i].push_back(addr[i]);
      end
    end
  end

  // Stream monitor: inputs change just after posedge, so the negedge sees the
  // values the next posedge will act on.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        stall_prev[i] = 1'b0;
      end else begin
        if (stall_prev[i]) begin
          chk($sformatf("hold_valid%0d", i), ovalid[i], 1);
          chk($sformatf("hold_byte%0d", i), obyte[i], held[i]);
        end
        if (ovalid[i] && ready[i]) got[i].push_back(obyte[i]);
        stall_prev[i] = ovalid[i] && !ready[i];
        held[i]       = obyte[i];
      end
    end
  end

  // mode 0: ready high; 1: ready low 5 cycles per high byte; 2: random ready;
  // 3: random ready with PROCESS_DONE dropped early in the dump.
  task automatic run_dump(input int sel, input int mode, input logic [15:0] base,
                          input int n, output int cycles);
    logic [7:0]  eb [$];
    logic [15:0] ea [$];
    logic [15:0] a;
    int          stalls;
    for (int k = 0; k < n; k++) begin
      a = base + 16'(k);
      ea.push_back(a);
      eb.push_back(mem[sel][a][15:8]);
      eb.push_back(mem[sel][a][7:0]);
    end
    got[sel].delete();
    rd_log[sel].delete();
    ready[sel] = (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    pd[sel]    = 1'b1;
    cycles     = 0;
    stalls     = 0;
    while (!done[sel] && cycles < 3000) begin
      tick;
      cycles++;
      case (mode)
        0: ready[sel] = 1'b1;
        1: begin
          if (ovalid[sel] && (got[sel].size() % 2 == 0) && stalls < 5) begin
            ready[sel] = 1'b0;
            stalls++;
          end else begin
            ready[sel] = 1'b1;
            if (got[sel].size() % 2 == 1) stalls = 0;
          end
        end
        default: begin
          ready[sel] = 1'($urandom_range(0, 1));
          if (mode == 3 && cycles == 3) pd[sel] = 1'b0;
        end
      endcase
    end
    chk($sformatf("done%0d", sel), done[sel], 1);
    chk($sformatf("busy_end%0d", sel), busy[sel], 0);
    chk($sformatf("byte_count%0d", sel), got[sel].size(), eb.size());
    for (int i = 0; i < eb.size() && i < got[sel].size(); i++)
      chk($sformatf("byte%0d_%0d", sel, i), got[sel][i], eb[i]);
    chk($sformatf("read_count%0d", sel), rd_log[sel].size(), ea.size());
    for (int i = 0; i < ea.size() && i < rd_log[sel].size(); i++)
      chk($sformatf("read_addr%0d_%0d", sel, i), rd_log[sel][i], ea[i]);
  endtask

  task automatic rearm;
    pd[0] = 1'b0;
    pd[1] = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    int          cyc;
    int          nreads;
    int          w;
    logic [7:0]  fixed_bytes [8];
    checks = 0;
    errors = 0;
    fixed_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07, 8'hFF, 8'h00};

    // Reset with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 2; s++) begin
        pd[s]    = 1'($urandom_range(0, 1));
        ready[s] = 1'($urandom_range(0, 1));
      end
      tick;
    end
    chk("rst_addr_a", addr[0], 16'h0010);
    chk("rst_addr_b", addr[1], 16'hFFFE);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_rd_en%0d", s), rd_en[s], 0);
      chk($sformatf("rst_byte%0d", s), obyte[s], 0);
      chk($sformatf("rst_valid%0d", s), ovalid[s], 0);
      chk($sformatf("rst_busy%0d", s), busy[s], 0);
      chk($sformatf("rst_done%0d", s), done[s], 0);
      chk($sformatf("rst_reads%0d", s), rd_log[s].size(), 0);
    end
    pd[0] = 1'b0;
    pd[1] = 1'b0;
    ready[0] = 1'b1;
    ready[1] = 1'b1;
    tick;
    rst = 1'b0;
    tick;

    // Directed 2x2 dump, ready tied high.
    mem[0][16'h0010] = 16'h1234;
    mem[0][16'h0011] = 16'hABCD;
    mem[0][16'h0012] = 16'h0007;
    mem[0][16'h0013] = 16'hFF00;
    run_dump(0, 0, 16'h0010, 4, cyc);
    chk("latency_a", cyc, 17);
    for (int i = 0; i < 8 && i < got[0].size(); i++)
      chk($sformatf("fixed_byte%0d", i), got[0][i], fixed_bytes[i]);

    // PROCESS_DONE held high: no second dump.
    for (int i = 0; i < 10; i++) tick;
    chk("held_reads", rd_log[0].size(), 4);
    chk("held_bytes", got[0].size(), 8);
    chk("held_done", done[0], 1);

    // Drop for one cycle, then a second dump with stalled high bytes.
    pd[0] = 1'b0;
    tick;
    chk("rearm_done_clear", done[0], 0);
    run_dump(0, 1, 16'h0010, 4, cyc);
    chk("latency_stall", cyc, 37);

    // Reset one cycle after the third byte transfers.
    rearm;
    got[0].delete();
    rd_log[0].delete();
    pd[0] = 1'b1;
    w = 0;
    while (got[0].size() < 3 && w < 100) begin
      tick;
      w++;
    end
    chk("third_byte_seen", got[0].size(), 3);
    nreads = rd_log[0].size();
    rst   = 1'b1;
    pd[0] = 1'b0;
    tick;
    chk("midrst_valid", ovalid[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_addr", addr[0], 16'h0010);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    chk("midrst_no_bytes", got[0].size(), 3);
    chk("midrst_no_reads", rd_log[0].size(), nreads);
    run_dump(0, 0, 16'h0010, 4, cyc);
    chk("latency_after_rst", cyc, 17);

    // 3x3 dump with address wrap, random data.
    for (int k = 0; k < 9; k++) mem[1][16'hFFFE + 16'(k)] = 16'($urandom);
    run_dump(1, 0, 16'hFFFE, 9, cyc);
    chk("latency_b", cyc, 37);

    // PROCESS_DONE already high when reset releases starts a dump.
    rst   = 1'b1;
    pd[0] = 1'b0;
    pd[1] = 1'b1;
    tick;
    rst = 1'b0;
    run_dump(1, 0, 16'hFFFE, 9, cyc);
    chk("latency_rst_high", cyc, 37);

    // Random data and random back-pressure on both instances.
    for (int r = 0; r < 6; r++) begin
      int sel;
      sel = r % 2;
      if (sel == 0) for (int k = 0; k < 4; k++) mem[0][16'h0010 + 16'(k)] = 16'($urandom);
      else          for (int k = 0; k < 9; k++) mem[1][16'hFFFE + 16'(k)] = 16'($urandom);
      rearm;
      run_dump(sel, (r >= 4) ? 3 : 2, (sel == 0) ? 16'h0010 : 16'hFFFE, (sel == 0) ? 4 : 9, cyc);
      if (r >= 4) begin
        tick;
        chk($sformatf("early_drop_rearm%0d", sel), done[sel], 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
